// File: rtl/aemb2_sysio_pkg.sv
// aemb2_sysio_pkg
// Shared definitions for the AEMB2 system I/O block: register word offsets,
// CTL/STS bit positions, default TX FIFO size and a byte-lane merge helper.
package aemb2_sysio_pkg;

    localparam int FIFO_AW_DEF = 2;

    // Register word offsets (dwb_adr_i[5:2])
    localparam logic [3:0] ADR_TMR = 4'd0;
    localparam logic [3:0] ADR_CMP = 4'd1;
    localparam logic [3:0] ADR_CTL = 4'd2;
    localparam logic [3:0] ADR_STS = 4'd3;
    localparam logic [3:0] ADR_TXD = 4'd4;

    // CTL bits
    localparam int CTL_TEN = 0;
    localparam int CTL_IEN = 1;

    // STS bits
    localparam int STS_IPEND = 0;
    localparam int STS_FULL  = 1;
    localparam int STS_EMPTY = 2;
    localparam int STS_OVF   = 3;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/aemb2_sysio_fifo.sv
// aemb2_sysio_fifo
// Small synchronous TX byte FIFO, depth 2**FIFO_AW.
// Ports:
//   sys_clk_i, sys_rst_i : clock, async active-high reset (empties the FIFO)
//   push, push_dat       : push request and byte
//   pop                  : pop request (ignored while empty)
//   head_dat             : head entry (0 while empty)
//   full, empty          : occupancy flags
//   drop                 : push rejected this cycle (full, no pop)
module aemb2_sysio_fifo
    import aemb2_sysio_pkg::*;
#(
    parameter int FIFO_AW = FIFO_AW_DEF
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic       push,
    input  logic [7:0] push_dat,
    input  logic       pop,
    output logic [7:0] head_dat,
    output logic       full,
    output logic       empty,
    output logic       drop
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               pop_ok;
    logic               push_ok;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

    // A pop in the same cycle frees the slot, so a push on full is still taken.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;

    // Gated so the output is a clean 0 after reset without clearing storage.
    assign head_dat = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge sys_clk_i) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/aemb2_sysio.sv
// aemb2_sysio
// System I/O slave for the AEMB2 data bus: a free-running compare timer with
// interrupt, and a byte TX FIFO toward a serial consumer.
// Ports:
//   sys_clk_i, sys_rst_i       : clock, async active-high reset
//   dwb_adr_i/dat_i/sel_i/stb_i/cyc_i/wre_i : bus request (word address [5:2])
//   dwb_dat_o, dwb_ack_o       : registered read data and single-cycle ack
//   sys_int_o                  : registered IPEND & IEN
//   txd_dat_o, txd_stb_o       : FIFO head byte and not-empty strobe
//   txd_ack_i                  : consumer takes the head byte
module aemb2_sysio
    import aemb2_sysio_pkg::*;
#(
    parameter int          FIFO_AW     = FIFO_AW_DEF,
    parameter logic [31:0] TMR_CMP_RST = 32'h00007FFF
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic [3:0]  dwb_adr_i,
    input  logic [31:0] dwb_dat_i,
    input  logic [3:0]  dwb_sel_i,
    input  logic        dwb_stb_i,
    input  logic        dwb_cyc_i,
    input  logic        dwb_wre_i,
    output logic [31:0] dwb_dat_o,
    output logic        dwb_ack_o,
    output logic        sys_int_o,
    output logic [7:0]  txd_dat_o,
    output logic        txd_stb_o,
    input  logic        txd_ack_i
);

    logic [31:0] tmr_q;
    logic [31:0] cmp_q;
    logic        ctl_ten;
    logic        ctl_ien;
    logic        ipend;
    logic        ovf;

    logic        bus_req;
    logic        bus_wr;
    logic        wr_tmr;
    logic        wr_cmp;
    logic        wr_ctl;
    logic        wr_sts;
    logic        tmr_hit;
    logic [31:0] rd_data;

    logic        fifo_push;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_drop;

    // The ack register itself blocks back-to-back requests, so a held strobe
    // is serviced every other cycle and each service is exactly one edge.
    assign bus_req = dwb_stb_i & dwb_cyc_i & ~dwb_ack_o;
    assign bus_wr  = bus_req & dwb_wre_i;
    assign wr_tmr  = bus_wr & (dwb_adr_i == ADR_TMR);
    assign wr_cmp  = bus_wr & (dwb_adr_i == ADR_CMP);
    assign wr_ctl  = bus_wr & (dwb_adr_i == ADR_CTL);
    assign wr_sts  = bus_wr & (dwb_adr_i == ADR_STS) & dwb_sel_i[0];

    assign fifo_push = bus_wr & (dwb_adr_i == ADR_TXD) & dwb_sel_i[3];
    assign tmr_hit   = ctl_ten & (tmr_q == cmp_q);

    always_comb begin
        rd_data = 32'h0;
        case (dwb_adr_i)
            ADR_TMR: rd_data = tmr_q;
            ADR_CMP: rd_data = cmp_q;
            ADR_CTL: begin
                rd_data[CTL_TEN] = ctl_ten;
                rd_data[CTL_IEN] = ctl_ien;
            end
            ADR_STS: begin
                rd_data[STS_IPEND] = ipend;
                rd_data[STS_FULL]  = fifo_full;
                rd_data[STS_EMPTY] = fifo_empty;
                rd_data[STS_OVF]   = ovf;
            end
            default: rd_data = 32'h0;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            dwb_ack_o <= 1'b0;
            dwb_dat_o <= 32'h0;
        end else begin
            dwb_ack_o <= bus_req;
            if (bus_req) dwb_dat_o <= rd_data;
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            tmr_q     <= 32'h0;
            cmp_q     <= TMR_CMP_RST;
            ctl_ten   <= 1'b0;
            ctl_ien   <= 1'b0;
            ipend     <= 1'b0;
            ovf       <= 1'b0;
            sys_int_o <= 1'b0;
        end else begin
            // Bus write to TMR wins over counting and wrapping.
            if (wr_tmr)
                tmr_q <= byte_merge(tmr_q, dwb_dat_i, dwb_sel_i);
            else if (ctl_ten)
                tmr_q <= tmr_hit ? 32'h0 : tmr_q + 32'h1;

            if (wr_cmp)
                cmp_q <= byte_merge(cmp_q, dwb_dat_i, dwb_sel_i);

            if (wr_ctl && dwb_sel_i[0]) begin
                ctl_ten <= dwb_dat_i[CTL_TEN];
                ctl_ien <= dwb_dat_i[CTL_IEN];
            end

            // Sticky flags: a new event beats a same-cycle write-1-to-clear.
            if (tmr_hit)
                ipend <= 1'b1;
            else if (wr_sts && dwb_dat_i[STS_IPEND])
                ipend <= 1'b0;

            if (fifo_drop)
                ovf <= 1'b1;
            else if (wr_sts && dwb_dat_i[STS_OVF])
                ovf <= 1'b0;

            sys_int_o <= ipend & ctl_ien;
        end
    end

    aemb2_sysio_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .push      (fifo_push),
        .push_dat  (dwb_dat_i[31:24]),
        .pop       (txd_ack_i),
        .head_dat  (txd_dat_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    assign txd_stb_o = ~fifo_empty;

endmodule

// File: tb/tb_aemb2_sysio.sv
`timescale 1ns/1ps
module tb_aemb2_sysio;

    logic        sys_clk_i = 1'b0;
    logic        sys_rst_i = 1'b1;
    logic [3:0]  dwb_adr_i = '0;
    logic [31:0] dwb_dat_i = '0;
    logic [3:0]  dwb_sel_i = '0;
    logic        dwb_stb_i = 1'b0;
    logic        dwb_cyc_i = 1'b0;
    logic        dwb_wre_i = 1'b0;
    logic [31:0] dwb_dat_o;
    logic        dwb_ack_o;
    logic        sys_int_o;
    logic [7:0]  txd_dat_o;
    logic        txd_stb_o;
    logic        txd_ack_i = 1'b0;

    aemb2_sysio dut (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .dwb_adr_i (dwb_adr_i),
        .dwb_dat_i (dwb_dat_i),
        .dwb_sel_i (dwb_sel_i),
        .dwb_stb_i (dwb_stb_i),
        .dwb_cyc_i (dwb_cyc_i),
        .dwb_wre_i (dwb_wre_i),
        .dwb_dat_o (dwb_dat_o),
        .dwb_ack_o (dwb_ack_o),
        .sys_int_o (sys_int_o),
        .txd_dat_o (txd_dat_o),
        .txd_stb_o (txd_stb_o),
        .txd_ack_i (txd_ack_i)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    always @(posedge sys_clk_i) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_exp_t;

    typedef struct {
        logic        wre;
        logic [3:0]  adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp;
        string       name;
    } vec_t;

    rd_exp_t    rd_q[$];
    logic [7:0] tx_q[$];
    vec_t       vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read scoreboard: each read ack pops the oldest expectation.
    always @(negedge sys_clk_i) begin
        if (!sys_rst_i && dwb_ack_o && !dwb_wre_i) begin
            if (rd_q.size() == 0) begin
                chk("unexpected_read_ack", 32'h1, 32'h0);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                chk(e.name, dwb_dat_o, e.exp);
            end
        end
    end

    // TX scoreboard: every accepted byte must leave in push order.
    always @(negedge sys_clk_i) begin
        if (!sys_rst_i && txd_stb_o && txd_ack_i) begin
            if (tx_q.size() == 0) begin
                chk("unexpected_tx_byte", {24'h0, txd_dat_o}, 32'h0);
            end else begin
                logic [7:0] b;
                b = tx_q.pop_front();
                chk("tx_byte", {24'h0, txd_dat_o}, {24'h0, b});
            end
        end
    end

    task automatic bus_xfer(input logic wre, input logic [3:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, input logic ack_tx);
        logic got;
        @(posedge sys_clk_i); #1;
        dwb_wre_i = wre;
        dwb_adr_i = adr;
        dwb_sel_i = sel;
        dwb_dat_i = dat;
        dwb_stb_i = 1'b1;
        dwb_cyc_i = 1'b1;
        if (ack_tx) txd_ack_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge sys_clk_i); #1;
            if (dwb_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        dwb_stb_i = 1'b0;
        dwb_cyc_i = 1'b0;
        if (!got) chk("ack_timeout", 32'h0, 32'h1);
    endtask

    task automatic bus_wr(input logic [3:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        bus_xfer(1'b1, adr, sel, dat, 1'b0);
    endtask

    task automatic bus_rd(input logic [3:0] adr, input logic [31:0] exp, input string name);
        rd_exp_t e;
        e.name = name;
        e.exp  = exp;
        rd_q.push_back(e);
        bus_xfer(1'b0, adr, 4'hF, 32'h0, 1'b0);
    endtask

    task automatic txd_push(input logic [7:0] ch, input logic accept, input logic ack_tx);
        if (accept) tx_q.push_back(ch);
        bus_xfer(1'b1, 4'd4, 4'h8, {ch, 24'h0}, ack_tx);
    endtask

    task automatic wait_int(input logic lvl, output int t, output logic ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk_i);
            if (sys_int_o == lvl) begin
                t  = cyc_cnt;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic drain_tx();
        logic done;
        done = 1'b0;
        txd_ack_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge sys_clk_i);
            if (!txd_stb_o) begin
                done = 1'b1;
                break;
            end
        end
        txd_ack_i = 1'b0;
        if (!done) chk("tx_drain_timeout", 32'h0, 32'h1);
        chk("tx_all_seen", tx_q.size(), 32'h0);
    endtask

    task automatic add_vec(input logic wre, input logic [3:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input logic [31:0] exp, input string name);
        vec_t v;
        v.wre = wre; v.adr = adr; v.sel = sel; v.dat = dat; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, tx;
        logic ok;

        add_vec(0, 4'd0,  4'hF, 32'h0,        32'h0000_0000, "rst_tmr");
        add_vec(0, 4'd1,  4'hF, 32'h0,        32'h0000_7FFF, "rst_cmp");
        add_vec(0, 4'd2,  4'hF, 32'h0,        32'h0000_0000, "rst_ctl");
        add_vec(0, 4'd3,  4'hF, 32'h0,        32'h0000_0004, "rst_sts");
        add_vec(0, 4'd4,  4'hF, 32'h0,        32'h0000_0000, "txd_reads_0");
        add_vec(0, 4'd7,  4'hF, 32'h0,        32'h0000_0000, "unmapped7");
        add_vec(0, 4'd15, 4'hF, 32'h0,        32'h0000_0000, "unmapped15");
        add_vec(1, 4'd1,  4'hF, 32'h12345678, 32'h0,         "");
        add_vec(0, 4'd1,  4'hF, 32'h0,        32'h12345678, "cmp_full_wr");
        add_vec(1, 4'd1,  4'h0, 32'hFFFFFFFF, 32'h0,         "");
        add_vec(0, 4'd1,  4'hF, 32'h0,        32'h12345678, "cmp_sel0");
        add_vec(1, 4'd1,  4'h1, 32'h000000AB, 32'h0,         "");
        add_vec(0, 4'd1,  4'hF, 32'h0,        32'h123456AB, "cmp_sel1");
        add_vec(1, 4'd1,  4'hC, 32'hAABBCCDD, 32'h0,         "");
        add_vec(0, 4'd1,  4'hF, 32'h0,        32'hAABB56AB, "cmp_selC");
        add_vec(1, 4'd9,  4'hF, 32'hFFFFFFFF, 32'h0,         "");
        add_vec(0, 4'd9,  4'hF, 32'h0,        32'h0000_0000, "unmapped_wr");
        add_vec(1, 4'd0,  4'hF, 32'h11223344, 32'h0,         "");
        add_vec(1, 4'd0,  4'h2, 32'h0000AA00, 32'h0,         "");
        add_vec(0, 4'd0,  4'hF, 32'h0,        32'h1122AA44, "tmr_lane_merge");
        add_vec(1, 4'd2,  4'hF, 32'hFFFFFFFC, 32'h0,         "");
        add_vec(0, 4'd2,  4'hF, 32'h0,        32'h0000_0000, "ctl_upper_ignored");
        add_vec(1, 4'd2,  4'h1, 32'h00000002, 32'h0,         "");
        add_vec(0, 4'd2,  4'hF, 32'h0,        32'h0000_0002, "ctl_ien");
        add_vec(1, 4'd2,  4'hF, 32'h00000000, 32'h0,         "");
        add_vec(0, 4'd2,  4'hF, 32'h0,        32'h0000_0000, "ctl_clear");
        add_vec(1, 4'd4,  4'h7, 32'h41000000, 32'h0,         "");
        add_vec(0, 4'd3,  4'hF, 32'h0,        32'h0000_0004, "txd_no_sel3");

        // Reset values while reset is held
        repeat (3) @(posedge sys_clk_i);
        #1;
        chk("rst_ack", dwb_ack_o, 32'h0);
        chk("rst_dat", dwb_dat_o, 32'h0);
        chk("rst_int", sys_int_o, 32'h0);
        chk("rst_txstb", txd_stb_o, 32'h0);
        chk("rst_txdat", txd_dat_o, 32'h0);
        @(negedge sys_clk_i);
        sys_rst_i = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].wre) bus_wr(vecs[i].adr, vecs[i].sel, vecs[i].dat);
            else             bus_rd(vecs[i].adr, vecs[i].exp, vecs[i].name);
        end

        // Strobe dropped between edges: no ack, no write
        @(posedge sys_clk_i); #1;
        dwb_wre_i = 1'b1; dwb_adr_i = 4'd1; dwb_sel_i = 4'hF; dwb_dat_i = 32'hDEAD;
        dwb_stb_i = 1'b1; dwb_cyc_i = 1'b1;
        #3;
        dwb_stb_i = 1'b0; dwb_cyc_i = 1'b0;
        @(posedge sys_clk_i); #1;
        chk("dropped_no_ack", dwb_ack_o, 32'h0);
        bus_rd(4'd1, 32'hAABB56AB, "dropped_no_write");

        // Interrupt enable / clear timing
        bus_wr(4'd1, 4'hF, 32'd9);
        bus_wr(4'd0, 4'hF, 32'd0);
        bus_wr(4'd2, 4'hF, 32'd1);
        repeat (12) @(posedge sys_clk_i);
        #1;
        chk("int_masked", sys_int_o, 32'h0);
        bus_rd(4'd3, 32'h5, "sts_ipend");
        bus_wr(4'd2, 4'hF, 32'd3);
        chk("int_lag_ien", sys_int_o, 32'h0);
        @(posedge sys_clk_i); #1;
        chk("int_after_ien", sys_int_o, 32'h1);
        bus_wr(4'd2, 4'hF, 32'd2);
        bus_wr(4'd3, 4'h1, 32'd1);
        chk("int_lag_clear", sys_int_o, 32'h1);
        @(posedge sys_clk_i); #1;
        chk("int_after_clear", sys_int_o, 32'h0);
        bus_rd(4'd3, 32'h4, "sts_ipend_cleared");

        // Wrap period: CMP = 9 gives IPEND every 10 cycles
        bus_wr(4'd0, 4'hF, 32'd0);
        bus_wr(4'd2, 4'hF, 32'd3);
        wait_int(1'b1, t1, ok);
        chk("int_rise1_seen", ok, 32'h1);
        bus_wr(4'd3, 4'h1, 32'd1);
        wait_int(1'b0, t2, ok);
        chk("int_fall_seen", ok, 32'h1);
        wait_int(1'b1, t2, ok);
        chk("int_rise2_seen", ok, 32'h1);
        chk("wrap_period", t2 - t1, 32'd10);
        bus_wr(4'd2, 4'hF, 32'd0);
        bus_wr(4'd3, 4'h1, 32'd1);
        bus_rd(4'd3, 32'h4, "sts_idle");

        // FIFO overflow, then in-order drain
        txd_push("A", 1'b1, 1'b0);
        chk("tx_stb_head", txd_stb_o, 32'h1);
        chk("tx_head_A", {24'h0, txd_dat_o}, 32'h41);
        txd_push("B", 1'b1, 1'b0);
        txd_push("C", 1'b1, 1'b0);
        txd_push("D", 1'b1, 1'b0);
        txd_push("E", 1'b0, 1'b0);
        bus_rd(4'd3, 32'hA, "sts_full_ovf");
        drain_tx();
        bus_rd(4'd3, 32'hC, "sts_empty_ovf");
        bus_wr(4'd3, 4'h1, 32'h8);
        bus_rd(4'd3, 32'h4, "sts_ovf_cleared");

        // Push on full with a same-cycle pop is accepted; pointers wrap
        txd_push("G", 1'b1, 1'b0);
        txd_push("H", 1'b1, 1'b0);
        txd_push("I", 1'b1, 1'b0);
        txd_push("J", 1'b1, 1'b0);
        bus_rd(4'd3, 32'h2, "sts_full");
        txd_push("K", 1'b1, 1'b1);
        drain_tx();
        bus_rd(4'd3, 32'h4, "sts_no_ovf");

        // Held strobe: ack on alternate cycles
        @(posedge sys_clk_i); #1;
        dwb_wre_i = 1'b0; dwb_adr_i = 4'd1; dwb_sel_i = 4'hF;
        dwb_stb_i = 1'b1; dwb_cyc_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rd_exp_t e;
            e.name = "burst_rd";
            e.exp  = 32'd9;
            rd_q.push_back(e);
        end
        for (int k = 1; k <= 6; k++) begin
            @(posedge sys_clk_i); #1;
            chk($sformatf("burst_ack_c%0d", k), dwb_ack_o, (k % 2 == 1) ? 32'h1 : 32'h0);
        end
        dwb_stb_i = 1'b0; dwb_cyc_i = 1'b0;

        // Reset mid-transfer with timer interrupt and FIFO contents live
        bus_wr(4'd2, 4'hF, 32'd3);
        wait_int(1'b1, tx, ok);
        chk("int_before_rst", ok, 32'h1);
        txd_push("X", 1'b1, 1'b0);
        txd_push("Y", 1'b1, 1'b0);
        @(posedge sys_clk_i); #1;
        dwb_wre_i = 1'b0; dwb_adr_i = 4'd1; dwb_sel_i = 4'hF;
        dwb_stb_i = 1'b1; dwb_cyc_i = 1'b1;
        @(posedge sys_clk_i); #1;
        chk("ack_before_rst", dwb_ack_o, 32'h1);
        #1;
        sys_rst_i = 1'b1;
        dwb_stb_i = 1'b0; dwb_cyc_i = 1'b0;
        tx_q.delete();
        #1;
        chk("rst_mid_ack", dwb_ack_o, 32'h0);
        chk("rst_mid_dat", dwb_dat_o, 32'h0);
        chk("rst_mid_int", sys_int_o, 32'h0);
        chk("rst_mid_txstb", txd_stb_o, 32'h0);
        chk("rst_mid_txdat", txd_dat_o, 32'h0);
        repeat (2) @(posedge sys_clk_i);
        @(negedge sys_clk_i);
        sys_rst_i = 1'b0;
        bus_rd(4'd0, 32'h0,      "rst2_tmr");
        bus_rd(4'd1, 32'h7FFF,   "rst2_cmp");
        bus_rd(4'd2, 32'h0,      "rst2_ctl");
        bus_rd(4'd3, 32'h4,      "rst2_sts");

        repeat (3) @(posedge sys_clk_i);
        chk("reads_all_answered", rd_q.size(), 32'h0);
        chk("tx_queue_empty", tx_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
